data_mem_mmio: RTL

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

---
 rtl/data_mem_mmio.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: byte-addressable data RAM plus memory-mapped LED, four-digit
// hex display (DIGITS) and an optional SYSTICK counter.
//   RAM     : 0x0000_0000 .. 4*RAM_WORDS-1, little-endian, not reset
//   LED     : 0x4000_000C  (word access only)
//   DIGITS  : 0x4000_0010  (word access only, 16 bits = four hex nibbles)
//   SYSTICK : 0x4000_0014  (only when DATA_MEM_SYSTICK_EN is defined)
// Optional feature macro: DATA_MEM_SYSTICK_EN
module data_mem_mmio #(
  parameter int RAM_WORDS = 1024,
  parameter int SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] Read_data,
  output logic        Misalign,
  output logic [7:0]  led,
  output logic [7:0]  BCD,
  output logic [3:0]  AN
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(SCAN_DIV);

  localparam logic [31:0] LED_ADDR     = 32'h4000_000C;
  localparam logic [31:0] DIGITS_ADDR  = 32'h4000_0010;
`ifdef DATA_MEM_SYSTICK_EN
  localparam logic [31:0] SYSTICK_ADDR = 32'h4000_0014;
`endif

  // Active-low seven-segment pattern {g..a} for one hex nibble.
  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction

  logic [31:0]        ram [RAM_WORDS];
  logic [15:0]        digits;
  logic [CNT_W-1:0]   scan_cnt;
  logic [1:0]         idx;

  logic               is_word, is_half, misaligned, in_ram;
  logic               hit_led, hit_digits, ram_we;
  logic [RAM_AW-1:0]  ram_idx;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic [31:0]        ram_word;
  logic [15:0]        half_v;
  logic [7:0]         byte_v;
`ifdef DATA_MEM_SYSTICK_EN
  logic [31:0]        systick;
  logic               hit_systick;
`endif

  // Decode access size, alignment, target region and RAM byte enables.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    is_word    = MemSize[1];
    is_half    = (MemSize == 2'b01);
    misaligned = (is_half && Address[0]) || (is_word && (Address[1:0] != 2'b00));
    in_ram     = (Address[31:RAM_AW+2] == '0);
    ram_idx    = Address[RAM_AW+1:2];
    hit_led    = is_word && (Address == LED_ADDR);
    hit_digits = is_word && (Address == DIGITS_ADDR);
`ifdef DATA_MEM_SYSTICK_EN
    hit_systick = is_word && (Address == SYSTICK_ADDR);
`endif
    ram_we     = MemWrite && in_ram && !misaligned;
    be         = 4'b0000;
    wlanes     = Write_data;
    if (is_word) begin
      be = 4'b1111;
    end else if (is_half) begin
      be     = Address[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{Write_data[15:0]}};
    end else begin
      be     = 4'b0001 << Address[1:0];
      wlanes = {4{Write_data[7:0]}};
    end
  end

  assign Misalign = (MemRead || MemWrite) && misaligned;

  // Combinational load path: pick lanes, then zero- or sign-extend.
  always_comb begin
    Read_data = '0;
    ram_word  = ram[ram_idx];
    half_v    = Address[1] ? ram_word[31:16] : ram_word[15:0];
    byte_v    = ram_word[8*Address[1:0] +: 8];
    if (MemRead && !misaligned) begin
      if (in_ram) begin
        if (is_word)      Read_data = ram_word;
        else if (is_half) Read_data = {{16{MemSigned & half_v[15]}}, half_v};
        else              Read_data = {{24{MemSigned & byte_v[7]}}, byte_v};
      end else if (hit_led) begin
        Read_data = {24'h0, led};
      end else if (hit_digits) begin
        Read_data = {16'h0, digits};
`ifdef DATA_MEM_SYSTICK_EN
      end else if (hit_systick) begin
        Read_data = systick;
`endif
      end
    end
  end

  // RAM byte-lane writes; a write coinciding with reset is dropped.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: RAM contents are never cleared; the reset branch only blocks the write.
    if (!reset) begin
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[ram_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // MMIO registers, scan counter/digit index and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led      <= '0;
      digits   <= '0;
      scan_cnt <= '0;
      idx      <= '0;
      AN       <= 4'b1110;
      BCD      <= 8'hC0;
    end else begin
      // NOTE: non-blocking assignments so AN/BCD see idx and digits from before this edge.
      if (MemWrite && hit_led)    led    <= Write_data[7:0];
      if (MemWrite && hit_digits) digits <= Write_data[15:0];
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      AN  <= ~(4'b0001 << idx);
      BCD <= {1'b1, seg(digits[4*idx +: 4])};
    end
  end

`ifdef DATA_MEM_SYSTICK_EN
  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick <= '0;
    else        systick <= systick + 32'd1;
  end
`endif

endmodule
